// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings and FSM states shared by the multiply/divide unit.
package muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift-add multiply / restoring divide registers, sign fixup and HI/LO.
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_in,
   input  logic             load,
   input  logic             div_sel,
   input  logic             sgn,
   input  logic             step,
   input  logic             fix,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [2*WIDTH-1:0] prod, prod_neg;
   logic [WIDTH-1:0]   dvs, a_mag, b_mag, rem_next, quo, rem;
   logic [WIDTH:0]     add, shl, sub;
   logic               is_div, dz, neg_q, neg_r, a_neg, b_neg;

   // prod holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
   always_comb begin
      a_neg    = sgn & a[WIDTH-1];
      b_neg    = sgn & b[WIDTH-1];
      a_mag    = a_neg ? -a : a;
      b_mag    = b_neg ? -b : b;
      add      = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{prod[0]}} & dvs};
      shl      = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
      sub      = shl - {1'b0, dvs};
      rem_next = sub[WIDTH] ? shl[WIDTH-1:0] : sub[WIDTH-1:0];
      prod_neg = -prod;
      quo      = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
      rem      = neg_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         prod   <= '0;
         dvs    <= '0;
         is_div <= 1'b0;
         dz     <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         if (load) begin
            prod   <= {{WIDTH{1'b0}}, div_sel ? (~|b ? a : a_mag) : b_mag};
            dvs    <= div_sel ? b_mag : a_mag;
            is_div <= div_sel;
            dz     <= div_sel & ~|b;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
         end else if (step) begin
            prod <= is_div ? {rem_next, prod[WIDTH-2:0], ~sub[WIDTH]} : {add, prod[WIDTH-1:1]};
         end
         if (fix && dz) begin
            hi <= prod[WIDTH-1:0];
            lo <= '1;
         end else if (fix && is_div) begin
            hi <= rem;
            lo <= quo;
         end else if (fix) begin
            {hi, lo} <= neg_q ? prod_neg : prod;
         end else begin
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO, MTHI/MTLO and hazard stall.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_in,
   input  logic             start_in,
   input  logic [2:0]       op_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             hilo_read_in,
   input  logic             flush_in,
   output logic             busy_out,
   output logic             done_out,
   output logic             stall_out,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic             launch, op_mul, op_div, sgn, step, fix;

   always_comb begin
      launch    = (state == S_IDLE) & start_in & ~flush_in;
      op_mul    = (op_in == OP_MULT) | (op_in == OP_MULTU);
      op_div    = (op_in == OP_DIV) | (op_in == OP_DIVU);
      sgn       = (op_in == OP_MULT) | (op_in == OP_DIV);
      step      = ((state == S_MUL) | (state == S_DIV)) & ~flush_in;
      fix       = (state == S_FIXUP) & ~flush_in;
      stall_out = busy_out & (start_in | hilo_read_in);
   end

   // divide-by-zero skips the iterations and lets FIXUP write the fixed result
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         state    <= S_IDLE;
         cnt      <= '0;
         busy_out <= 1'b0;
         done_out <= 1'b0;
      end else begin
         done_out <= 1'b0;
         case (state)
            S_IDLE: begin
               if (launch && (op_mul || op_div)) begin
                  state    <= op_mul ? S_MUL : (~|b_in ? S_FIXUP : S_DIV);
                  cnt      <= CNT_W'(WIDTH - 1);
                  busy_out <= 1'b1;
               end
            end
            S_MUL, S_DIV: begin
               if (flush_in) begin
                  state    <= S_IDLE;
                  busy_out <= 1'b0;
               end else if (cnt == '0) begin
                  state <= S_FIXUP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_FIXUP: begin
               state    <= flush_in ? S_IDLE : S_DONE;
               busy_out <= 1'b0;
               done_out <= ~flush_in;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk     (clk),
      .reset_in(reset_in),
      .load    (launch & (op_mul | op_div)),
      .div_sel (op_div),
      .sgn     (sgn),
      .step    (step),
      .fix     (fix),
      .wr_hi   (launch & (op_in == OP_MTHI)),
      .wr_lo   (launch & (op_in == OP_MTLO)),
      .a       (a_in),
      .b       (b_in),
      .hi      (hi_out),
      .lo      (lo_out)
   );

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a scoreboard queue checked on every done_out pulse.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset_in = 1'b0;
   logic        start_in = 1'b0;
   logic [2:0]  op_in = 3'd0;
   logic [31:0] a_in = '0;
   logic [31:0] b_in = '0;
   logic        hilo_read_in = 1'b0;
   logic        flush_in = 1'b0;
   logic        busy_out, done_out, stall_out;
   logic [31:0] hi_out, lo_out;

   logic [63:0] q[$];
   int checks = 0;
   int errors = 0;

   muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .reset_in(reset_in), .start_in(start_in), .op_in(op_in),
      .a_in(a_in), .b_in(b_in), .hilo_read_in(hilo_read_in), .flush_in(flush_in),
      .busy_out(busy_out), .done_out(done_out), .stall_out(stall_out),
      .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done_out) begin
         if (q.size() == 0) begin
            chk("unexpected done", 64'd1, 64'd0);
         end else begin
            logic [63:0] e;
            e = q.pop_front();
            chk("hi", {32'd0, hi_out}, {32'd0, e[63:32]});
            chk("lo", {32'd0, lo_out}, {32'd0, e[31:0]});
         end
      end
   end

   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input bit push);
      @(negedge clk);
      start_in = 1'b1;
      op_in = op;
      a_in = a;
      b_in = b;
      if (push) q.push_back({eh, el});
      @(posedge clk);
      #1 start_in = 1'b0;
   endtask

   // k: expected edge after the start edge at which done rises (-1 skips the latency check)
   task automatic wait_done(input string name, input int k);
      int n = 0;
      int busy_n = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (done_out) break;
         busy_n += int'(busy_out);
      end
      if (!done_out) begin
         chk({name, " timeout"}, 64'd0, 64'd1);
         if (q.size() != 0) void'(q.pop_front());
      end else begin
         if (k >= 0) chk({name, " latency"}, 64'(n - 1), 64'(k));
         if (k == 33) chk({name, " busy cycles"}, 64'(busy_n), 64'd33);
         hilo_read_in = 1'b1;
         #1 chk({name, " no stall in done"}, {63'd0, stall_out}, 64'd0);
         hilo_read_in = 1'b0;
      end
   endtask

   initial begin
      #2;
      chk("reset hi", {32'd0, hi_out}, 64'd0);
      chk("reset lo", {32'd0, lo_out}, 64'd0);
      chk("reset busy/done/stall", {61'd0, busy_out, done_out, stall_out}, 64'd0);
      repeat (2) @(negedge clk);
      reset_in = 1'b1;

      launch(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1);
      wait_done("multu max", 33);
      launch(3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1);
      wait_done("mult -3*5", 33);
      launch(3'd0, 32'hFFFFFFFC, 32'hFFFFFFFA, 32'h0, 32'h18, 1);
      wait_done("mult -4*-6", 33);
      launch(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1);
      wait_done("div -7/2", 33);
      launch(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1);
      wait_done("divu 100/7", 33);
      launch(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1);
      wait_done("div overflow", 33);
      launch(3'd2, 32'hFFFFFFF8, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFE, 1);
      wait_done("div -8/3", 33);
      launch(3'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1);
      wait_done("divu by zero", 1);
      launch(3'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1);
      wait_done("div by zero", 1);

      // stall while busy; the second start must be dropped
      launch(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1);
      @(negedge clk);
      hilo_read_in = 1'b1;
      #1 chk("stall on hilo read", {63'd0, stall_out}, 64'd1);
      @(negedge clk);
      hilo_read_in = 1'b0;
      start_in = 1'b1;
      op_in = 3'd3;
      a_in = 32'd1;
      b_in = 32'd1;
      #1 chk("stall on start", {63'd0, stall_out}, 64'd1);
      @(negedge clk);
      start_in = 1'b0;
      wait_done("multu 6*7", -1);
      repeat (5) @(negedge clk);
      chk("second op not launched", {63'd0, busy_out}, 64'd0);

      // flush mid-multiply
      launch(3'd0, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, 0);
      repeat (10) @(negedge clk);
      flush_in = 1'b1;
      @(posedge clk);
      #1 flush_in = 1'b0;
      chk("flush busy", {63'd0, busy_out}, 64'd0);
      repeat (40) @(negedge clk);
      chk("flush hi kept", {32'd0, hi_out}, 64'd0);
      chk("flush lo kept", {32'd0, lo_out}, 64'd42);
      launch(3'd4, 32'hA5A5A5A5, 32'd0, 32'd0, 32'd0, 0);
      chk("mthi hi", {32'd0, hi_out}, 64'hA5A5A5A5);
      chk("mthi lo untouched", {32'd0, lo_out}, 64'd42);
      chk("mthi not busy", {63'd0, busy_out}, 64'd0);
      launch(3'd5, 32'h5A5A0001, 32'd0, 32'd0, 32'd0, 0);
      chk("mtlo lo", {32'd0, lo_out}, 64'h5A5A0001);

      // asynchronous reset mid-divide
      launch(3'd3, 32'd100, 32'd7, 32'd0, 32'd0, 0);
      repeat (4) @(negedge clk);
      #3 reset_in = 1'b0;
      #1;
      chk("async reset hi", {32'd0, hi_out}, 64'd0);
      chk("async reset lo", {32'd0, lo_out}, 64'd0);
      chk("async reset busy/done", {62'd0, busy_out, done_out}, 64'd0);
      @(negedge clk);
      reset_in = 1'b1;
      launch(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1);
      wait_done("divu after reset", 33);

      repeat (3) @(negedge clk);
      chk("scoreboard drained", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
